quad_display_ctrl: RTL and testbench
====================================

Name: quad_display_ctrl

Overview:
- Sequencer for the 2x2 quad-view VGA output stage of the motion-detect pipeline.
- Maps the 640x480 raster from the VGA timing generator onto four 320x240 quadrants:
  - per-quadrant enables
  - one shared QVGA frame-buffer read address
- Owns the frame-level motion alarm state machine (warm-up, idle, alert with hold-off) that drives the motion flag consumed by the RGB output mux.

Parameters:
- H_ACTIVE, 640, active pixels per line; quadrant width = H_ACTIVE/2.
- V_ACTIVE, 480, active lines per frame; quadrant height = V_ACTIVE/2.
- SETTLE_FRAMES, 4, frames after reset during which motion_in is ignored (background not yet valid); 1..15.
- HOLD_FRAMES, 8, frames motion_detected stays high after the last frame containing motion; 1..255.

Ports:
- clk  input  1  pixel clock
- reset  input  1  synchronous, active-high reset
- x_pixel  input  10  current raster column from VGA timing
- y_pixel  input  10  current raster row from VGA timing
- display_enable_in  input  1  raster inside active area
- vref  input  1  vertical sync/reference; a rising edge marks a frame boundary
- motion_in  input  1  per-pixel motion hit from the difference/threshold stage
- display_enable  output  1  registered copy of display_enable_in
- left_top_enable  output  1  quadrant 0 active (x<320, y<240)
- right_top_enable  output  1  quadrant 1 active (x>=320, y<240)
- left_bot_enable  output  1  quadrant 2 active (x<320, y>=240)
- right_bot_enable  output  1  quadrant 3 active (x>=320, y>=240)
- fb_rd_addr  output  17  frame-buffer read address, y_local*320 + x_local
- frame_start  output  1  one-cycle pulse on each vref rising edge
- motion_detected  output  1  alarm flag for the overlay
- alarm_state  output  2  FSM state: 0 WARMUP, 1 IDLE, 2 ALERT
- hold_count  output  8  remaining hold frames (debug)

Behaviour:
- Reset is synchronous to clk. On reset:
  - all outputs = 0, except alarm_state = WARMUP
  - internal settle counter = 0, motion latch = 0, prev_vref = 0
- Output registering and latency:
  - display_enable, all quadrant enables and fb_rd_addr are registered: latency exactly 1 clk from x/y/display_enable_in.
  - All quadrant enables are 0 when display_enable_in = 0.
  - Exactly one quadrant enable is high when display_enable_in = 1.
- Local coordinates:
  - x_local = x_pixel - 320 if x_pixel >= 320, else x_pixel.
  - y_local = y_pixel - 240 if y_pixel >= 240, else y_pixel.
- Address arithmetic:
  - fb_rd_addr = (y_local<<8) + (y_local<<6) + x_local, computed at 17-bit width with no truncation; max value 76799.
  - When display_enable_in = 0, fb_rd_addr holds its last value.
- Frame boundary:
  - frame_start = vref & ~prev_vref, registered as a 1-cycle pulse; prev_vref updates every clk.
- Motion latch:
  - Set on any clk where motion_in = 1 and display_enable_in = 1.
  - At frame_start it is evaluated, then cleared.
  - If motion_in and frame_start coincide, that hit counts toward the ending frame; the latch is still cleared.
- FSM transitions are evaluated only on frame_start:
  - WARMUP: settle counter increments; when it reaches SETTLE_FRAMES go to IDLE. Motion is ignored and motion_detected = 0.
  - IDLE: if the latch is set, go to ALERT, set hold_count = HOLD_FRAMES and motion_detected = 1.
  - ALERT, latch set: hold_count reloads to HOLD_FRAMES.
  - ALERT, latch clear: hold_count decrements. When the value before the decrement is 1, go to IDLE, set hold_count = 0 and motion_detected = 0.
- motion_detected changes only on the clk following frame_start, so the overlay is never torn mid-frame.
- Reset asserted mid-frame or mid-ALERT returns the block to WARMUP immediately; the settle period restarts.
- x_pixel >= H_ACTIVE or y_pixel >= V_ACTIVE with display_enable_in = 1 is out of spec. Quadrant decode still follows the >= comparisons, and the address is not clamped.

Optional Feature:
- Macro: MOTION_BLINK_EN.
- Defined:
  - An internal frame-parity toggle flips on each frame_start while in ALERT.
  - motion_detected = 1 only on even-parity frames once hold_count < HOLD_FRAMES, giving a blinking bar during hold-off.
  - The first alert frame is always 1.
  - Parity clears on entry to IDLE.
- Not defined: motion_detected is steady high for the whole ALERT state. No parity register is synthesised.

Test Plan:
- Reset, then raster at x=319,y=239 and x=320,y=240 with display_enable_in=1.
  - One clk later: left_top_enable=1 with fb_rd_addr=76799.
  - Then right_bot_enable=1 with fb_rd_addr=0.
  - All other enables 0.
- x=5,y=250, display_enable_in=1 -> left_bot_enable=1, fb_rd_addr=3205. Dropping display_enable_in -> all enables 0, address held at 3205.
- Motion hit in frames 1-3 after reset (SETTLE_FRAMES=4) -> alarm_state stays WARMUP and motion_detected=0. IDLE is reached at the 4th frame_start.
- IDLE, motion in one frame, then HOLD_FRAMES=8 clean frames -> ALERT at the next frame_start. hold_count goes 8,7,...,1; IDLE and motion_detected=0 at the 8th clean frame_start.
- ALERT with hold_count=3, motion_in pulses on the same clk as frame_start -> hold_count reloads to 8 and the latch is cleared.
- Reset asserted for 1 clk while in ALERT mid-frame -> next clk: motion_detected=0, alarm_state=WARMUP, hold_count=0, all enables 0.

Source files
------------

// File: rtl/quad_display_ctrl.sv
// quad_display_ctrl: 2x2 quad-view raster sequencer and frame-level motion alarm FSM (option: MOTION_BLINK_EN)
module quad_display_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int SETTLE_FRAMES = 4,
  parameter int HOLD_FRAMES = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  x_pixel,
  input  logic [9:0]  y_pixel,
  input  logic        display_enable_in,
  input  logic        vref,
  input  logic        motion_in,
  output logic        display_enable,
  output logic        left_top_enable,
  output logic        right_top_enable,
  output logic        left_bot_enable,
  output logic        right_bot_enable,
  output logic [16:0] fb_rd_addr,
  output logic        frame_start,
  output logic        motion_detected,
  output logic [1:0]  alarm_state,
  output logic [7:0]  hold_count
);
  localparam logic [1:0] WARMUP = 2'd0, IDLE = 2'd1, ALERT = 2'd2;
  localparam logic [9:0] QW = 10'(H_ACTIVE / 2), QH = 10'(V_ACTIVE / 2);
  localparam logic [7:0] HOLD = 8'(HOLD_FRAMES);
  localparam logic [3:0] SETTLE = 4'(SETTLE_FRAMES);
  logic right, bot, prev_vref, latch, hit, md_n;
  logic [9:0] x_local, y_local;
  logic [16:0] addr;
  logic [3:0] settle_cnt, settle_n;
  logic [1:0] state_n;
  logic [7:0] hold_n;
  assign right = x_pixel >= QW;
  assign bot = y_pixel >= QH;
  assign x_local = right ? x_pixel - QW : x_pixel;
  assign y_local = bot ? y_pixel - QH : y_pixel;
  assign addr = 17'(y_local) * 17'(QW) + 17'(x_local);
  // a hit on the frame_start cycle still belongs to the frame that is ending
  assign hit = latch | (motion_in & display_enable_in);
  always_comb begin
    state_n = alarm_state;
    hold_n = hold_count;
    settle_n = settle_cnt;
    if (frame_start) begin
      if (alarm_state == WARMUP) begin
        settle_n = settle_cnt + 4'd1;
        state_n = settle_n == SETTLE ? IDLE : WARMUP;
      end else if (alarm_state == IDLE) begin
        state_n = hit ? ALERT : IDLE;
        hold_n = hit ? HOLD : 8'd0;
      end else begin
        state_n = (!hit && hold_count == 8'd1) ? IDLE : ALERT;
        hold_n = hit ? HOLD : hold_count - 8'd1;
      end
    end
  end
`ifdef MOTION_BLINK_EN
  logic parity, parity_n;
  assign parity_n = frame_start ? ((alarm_state == ALERT && state_n == ALERT) ? ~parity : 1'b0) : parity;
  assign md_n = frame_start ? (state_n == ALERT && (hold_n == HOLD || !parity_n)) : motion_detected;
  always_ff @(posedge clk)
    if (reset) parity <= 1'b0;
    else parity <= parity_n;
`else
  assign md_n = frame_start ? state_n == ALERT : motion_detected;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      display_enable <= 1'b0;
      left_top_enable <= 1'b0;
      right_top_enable <= 1'b0;
      left_bot_enable <= 1'b0;
      right_bot_enable <= 1'b0;
      fb_rd_addr <= '0;
      frame_start <= 1'b0;
      prev_vref <= 1'b0;
      latch <= 1'b0;
      settle_cnt <= '0;
      alarm_state <= WARMUP;
      hold_count <= '0;
      motion_detected <= 1'b0;
    end else begin
      display_enable <= display_enable_in;
      left_top_enable <= display_enable_in & ~right & ~bot;
      right_top_enable <= display_enable_in & right & ~bot;
      left_bot_enable <= display_enable_in & ~right & bot;
      right_bot_enable <= display_enable_in & right & bot;
      fb_rd_addr <= display_enable_in ? addr : fb_rd_addr;
      frame_start <= vref & ~prev_vref;
      prev_vref <= vref;
      latch <= frame_start ? 1'b0 : hit;
      settle_cnt <= settle_n;
      alarm_state <= state_n;
      hold_count <= hold_n;
      motion_detected <= md_n;
    end
  end
endmodule

// File: tb/tb_quad_display_ctrl.sv
// tb_quad_display_ctrl: directed self-checking bench for quad_display_ctrl (default build, MOTION_BLINK_EN undefined)
module tb_quad_display_ctrl;
  logic clk = 1'b0, reset = 1'b0, display_enable_in = 1'b0, vref = 1'b0, motion_in = 1'b0;
  logic [9:0] x_pixel = '0, y_pixel = '0;
  logic display_enable, left_top_enable, right_top_enable, left_bot_enable, right_bot_enable;
  logic frame_start, motion_detected;
  logic [16:0] fb_rd_addr;
  logic [1:0] alarm_state;
  logic [7:0] hold_count;
  int n_checks = 0, n_fail = 0;
  quad_display_ctrl dut (
    .clk(clk), .reset(reset), .x_pixel(x_pixel), .y_pixel(y_pixel),
    .display_enable_in(display_enable_in), .vref(vref), .motion_in(motion_in),
    .display_enable(display_enable), .left_top_enable(left_top_enable),
    .right_top_enable(right_top_enable), .left_bot_enable(left_bot_enable),
    .right_bot_enable(right_bot_enable), .fb_rd_addr(fb_rd_addr),
    .frame_start(frame_start), .motion_detected(motion_detected),
    .alarm_state(alarm_state), .hold_count(hold_count)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic pixel(input logic [9:0] x, input logic [9:0] y, input logic de);
    x_pixel = x;
    y_pixel = y;
    display_enable_in = de;
    tick();
  endtask
  task automatic hit();
    motion_in = 1'b1;
    display_enable_in = 1'b1;
    tick();
    motion_in = 1'b0;
    display_enable_in = 1'b0;
  endtask
  task automatic pulse();
    vref = 1'b1;
    tick();
    vref = 1'b0;
    tick();
  endtask
  function automatic logic [3:0] quads();
    return {left_top_enable, right_top_enable, left_bot_enable, right_bot_enable};
  endfunction
  initial begin
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_quads", 32'(quads()), 0);
    check("rst_addr", 32'(fb_rd_addr), 0);
    check("rst_state", 32'(alarm_state), 0);
    check("rst_md", 32'(motion_detected), 0);
    check("rst_hold", 32'(hold_count), 0);
    pixel(10'd319, 10'd239, 1'b1);
    check("lt_quads", 32'(quads()), 4'b1000);
    check("lt_addr", 32'(fb_rd_addr), 76799);
    check("de_reg", 32'(display_enable), 1);
    pixel(10'd320, 10'd240, 1'b1);
    check("rb_quads", 32'(quads()), 4'b0001);
    check("rb_addr", 32'(fb_rd_addr), 0);
    pixel(10'd400, 10'd100, 1'b1);
    check("rt_quads", 32'(quads()), 4'b0100);
    check("rt_addr", 32'(fb_rd_addr), 32080);
    pixel(10'd5, 10'd250, 1'b1);
    check("lb_quads", 32'(quads()), 4'b0010);
    check("lb_addr", 32'(fb_rd_addr), 3205);
    pixel(10'd100, 10'd100, 1'b0);
    check("off_quads", 32'(quads()), 0);
    check("off_addr", 32'(fb_rd_addr), 3205);
    check("off_de", 32'(display_enable), 0);
    vref = 1'b1;
    tick();
    check("fs_high", 32'(frame_start), 1);
    tick();
    check("fs_pulse", 32'(frame_start), 0);
    vref = 1'b0;
    tick();
    check("warm1_state", 32'(alarm_state), 0);
    for (int i = 2; i <= 3; i++) begin
      hit();
      pulse();
      check($sformatf("warm%0d_state", i), 32'(alarm_state), 0);
      check($sformatf("warm%0d_md", i), 32'(motion_detected), 0);
    end
    hit();
    pulse();
    check("idle_state", 32'(alarm_state), 1);
    check("idle_md", 32'(motion_detected), 0);
    hit();
    pulse();
    check("alert_state", 32'(alarm_state), 2);
    check("alert_md", 32'(motion_detected), 1);
    check("alert_hold", 32'(hold_count), 8);
    for (int i = 7; i >= 1; i--) begin
      pulse();
      check($sformatf("hold_%0d", i), 32'(hold_count), 32'(i));
      check($sformatf("hold_md_%0d", i), 32'(motion_detected), 1);
    end
    pulse();
    check("exit_state", 32'(alarm_state), 1);
    check("exit_md", 32'(motion_detected), 0);
    check("exit_hold", 32'(hold_count), 0);
    hit();
    pulse();
    for (int i = 0; i < 5; i++) pulse();
    check("pre_coin_hold", 32'(hold_count), 3);
    vref = 1'b1;
    tick();
    vref = 1'b0;
    motion_in = 1'b1;
    display_enable_in = 1'b1;
    tick();
    motion_in = 1'b0;
    display_enable_in = 1'b0;
    check("coin_hold", 32'(hold_count), 8);
    pulse();
    check("latch_clr_hold", 32'(hold_count), 7);
    x_pixel = 10'd10;
    y_pixel = 10'd10;
    hit();
    display_enable_in = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    display_enable_in = 1'b0;
    check("mid_rst_md", 32'(motion_detected), 0);
    check("mid_rst_state", 32'(alarm_state), 0);
    check("mid_rst_hold", 32'(hold_count), 0);
    check("mid_rst_quads", 32'(quads()), 0);
    for (int i = 0; i < 3; i++) pulse();
    check("resettle_state", 32'(alarm_state), 0);
    pulse();
    check("resettle_idle", 32'(alarm_state), 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
